// File: rtl/ra_bist_host_pkg.sv
// Shared encodings for the array-local BIST host: op codes, ctl/status word prefixes,
// FSM states and the decoded-status record.
package ra_bist_host_pkg;

  localparam int BEAT_W = 24;
  localparam int DAT_W  = 3 * BEAT_W;

  typedef enum logic [1:0] {
    OP_FUNC  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BIST  = 2'b11
  } op_e;

  localparam logic [7:0]  CTL_READ  = 8'h80;
  localparam logic [7:0]  CTL_WRITE = 8'h90;
  localparam logic [7:0]  CTL_WDAT  = 8'hA0;
  localparam logic [7:0]  CTL_BIST  = 8'hF0;
  localparam logic [31:0] CTL_FUNC  = 32'h0000_0000;
  localparam logic [31:0] CTL_HOLD  = 32'h7000_0000;

  localparam logic [5:0]  STS_BEAT  = 6'b110000;
  localparam logic [7:0]  STS_PASS  = 8'hD0;
  localparam logic [7:0]  STS_FAIL  = 8'hD1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDAT,
    ST_WAIT,
    ST_RSP
  } state_e;

  typedef enum logic [1:0] {
    STS_NONE,
    STS_RBEAT,
    STS_DONE
  } sts_kind_e;

  typedef struct packed {
    sts_kind_e         kind;
    logic [1:0]        idx;
    logic [BEAT_W-1:0] dat;
    logic [7:0]        tid;
    logic              fail;
  } sts_t;

  // Beat 0 is the most significant 24 bits of the 72-bit word.
  function automatic logic [BEAT_W-1:0] get_beat(input logic [DAT_W-1:0] d, input logic [1:0] idx);
    logic [BEAT_W-1:0] b;
    case (idx)
      2'd0:    b = d[71:48];
      2'd1:    b = d[47:24];
      default: b = d[23:0];
    endcase
    return b;
  endfunction

  function automatic logic [DAT_W-1:0] put_beat(input logic [DAT_W-1:0] d, input logic [1:0] idx,
                                                input logic [BEAT_W-1:0] b);
    logic [DAT_W-1:0] r;
    r = d;
    case (idx)
      2'd0:    r[71:48] = b;
      2'd1:    r[47:24] = b;
      default: r[23:0]  = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ra_bist_host_if.sv
// Host request/response bus plus the ctl/status pair of one local BIST block.
// master = test side (issues requests, returns status); slave = ra_bist_host.
interface ra_bist_host_if;
  import ra_bist_host_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [5:0]        req_adr;
  logic [DAT_W-1:0]  req_dat;
  logic [7:0]        req_test;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic              rsp_fail;
  logic [DAT_W-1:0]  rsp_dat;

  logic [31:0]       ctl;
  logic [31:0]       status;

  modport master (
    output req_valid, req_op, req_adr, req_dat, req_test, rsp_ready, status,
    input  req_ready, rsp_valid, rsp_err, rsp_fail, rsp_dat, ctl
  );

  modport slave (
    input  req_valid, req_op, req_adr, req_dat, req_test, rsp_ready, status,
    output req_ready, rsp_valid, rsp_err, rsp_fail, rsp_dat, ctl
  );

endinterface

// File: rtl/ra_bist_status_dec.sv
// Combinational classifier of the BIST status word into read-beat / bist-done / ignored,
// with beat index, beat data, test id and fail flag extracted.
module ra_bist_status_dec
  import ra_bist_host_pkg::*;
(
  input  logic [31:0] status_i,
  output sts_t        sts_o
);

  always_comb begin
    sts_o.kind = STS_NONE;
    sts_o.idx  = status_i[25:24];
    sts_o.dat  = status_i[23:0];
    sts_o.tid  = status_i[7:0];
    sts_o.fail = status_i[24];
    if (status_i[31:26] == STS_BEAT) begin
      sts_o.kind = STS_RBEAT;
    end else if ((status_i[31:24] == STS_PASS || status_i[31:24] == STS_FAIL) &&
                 status_i[23:8] == 16'h0000) begin
      sts_o.kind = STS_DONE;
    end
  end

endmodule

// File: rtl/ra_bist_host.sv
// Turns one host transaction into a ctl word sequence and parses the status stream back.
// Write: rsp 5 cycles after accept; read/bist: rsp 1 cycle after the final status or at TIMEOUT.
module ra_bist_host
  import ra_bist_host_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  ra_bist_host_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_e            state_q;
  op_e               op_q;
  logic [DAT_W-1:0]  wdat_q;
  logic [7:0]        test_q;
  logic [1:0]        beat_q;
  logic [7:0]        timer_q;
  logic [7:0]        timer_d;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_fail_q;
  logic [DAT_W-1:0]  rsp_dat_q;
  logic [31:0]       ctl_q;
  sts_t              sts;

  ra_bist_status_dec u_dec (
    .status_i (bus.status),
    .sts_o    (sts)
  );

  assign timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FUNC;
      wdat_q      <= '0;
      test_q      <= '0;
      beat_q      <= '0;
      timer_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_fail_q  <= 1'b0;
      rsp_dat_q   <= '0;
      ctl_q       <= CTL_FUNC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_q        <= op_e'(bus.req_op);
            wdat_q      <= bus.req_dat;
            test_q      <= bus.req_test;
            beat_q      <= '0;
            timer_q     <= '0;
            rsp_dat_q   <= '0;
            req_ready_q <= 1'b0;
            state_q     <= ST_CMD;
            case (op_e'(bus.req_op))
              OP_FUNC:  ctl_q <= CTL_FUNC;
              OP_READ:  ctl_q <= {CTL_READ, 18'h0, bus.req_adr};
              OP_WRITE: ctl_q <= {CTL_WRITE, 18'h0, bus.req_adr};
              default:  ctl_q <= {CTL_BIST, 16'h0, bus.req_test};
            endcase
          end
        end

        ST_CMD: begin
          timer_q <= timer_d;
          case (op_q)
            OP_FUNC: begin
              ctl_q       <= CTL_FUNC;
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
            end
            OP_WRITE: begin
              ctl_q   <= {CTL_WDAT, get_beat(wdat_q, 2'd0)};
              state_q <= ST_WDAT;
            end
            default: begin
              ctl_q   <= CTL_HOLD;
              state_q <= ST_WAIT;
            end
          endcase
        end

        ST_WDAT: begin
          if (beat_q == 2'd2) begin
            ctl_q       <= CTL_HOLD;
            beat_q      <= '0;
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
          end else begin
            ctl_q  <= {CTL_WDAT, get_beat(wdat_q, beat_q + 2'd1)};
            beat_q <= beat_q + 2'd1;
          end
        end

        ST_WAIT: begin
          ctl_q   <= CTL_HOLD;
          timer_q <= timer_d;
          // Timeout is the fallback; a completing status word in the same cycle overrides it.
          if (timer_d >= TIMEOUT_C) begin
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
          end
          if (op_q == OP_READ && sts.kind == STS_RBEAT) begin
            if (sts.idx != beat_q) begin
              rsp_err_q   <= 1'b1;
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
            end else begin
              rsp_dat_q <= put_beat(rsp_dat_q, sts.idx, sts.dat);
              beat_q    <= beat_q + 2'd1;
              if (beat_q == 2'd2) begin
                rsp_err_q   <= 1'b0;
                state_q     <= ST_RSP;
                rsp_valid_q <= 1'b1;
              end
            end
          end else if (op_q == OP_BIST && sts.kind == STS_DONE && sts.tid == test_q) begin
            rsp_fail_q  <= sts.fail;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
          end
        end

        ST_RSP: begin
          // ctl keeps its value: the array stays in test mode until a functional op.
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_fail_q  <= 1'b0;
            rsp_dat_q   <= '0;
            beat_q      <= '0;
            timer_q     <= '0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          ctl_q       <= CTL_FUNC;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_fail  = rsp_fail_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.ctl       = ctl_q;

endmodule

// File: tb/tb_ra_bist_host.sv
// Bench for ra_bist_host: directed vector table, reset/backpressure sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_ra_bist_host;

  localparam int TO = 16;
  localparam int NS = 40;

  logic clk;
  logic reset;

  ra_bist_host_if bif ();

  ra_bist_host #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] sched [NS];
  logic [31:0] m_ctl [NS];
  int          m_off;
  logic        m_err;
  logic        m_fail;
  logic [71:0] m_dat;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  adr;
    logic [71:0] dat;
    logic [7:0]  test;
    int          k0, k1, k2;
    logic [31:0] w0, w1, w2;
    int          hold;
    logic [31:0] e_ctl0;
    int          e_off;
    logic        e_err;
    logic        e_fail;
    logic [71:0] e_dat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: offsets count cycles from the command-word cycle.
  task automatic model(input logic [1:0] op, input logic [5:0] adr, input logic [71:0] dat,
                       input logic [7:0] test);
    int          nxt;
    logic [31:0] w;
    logic [71:0] acc;
    m_err = 1'b0;
    m_fail = 1'b0;
    m_dat = '0;
    m_off = 0;
    for (int k = 0; k < NS; k++) m_ctl[k] = 32'h7000_0000;
    if (op == 2'b00) begin
      m_off = 1;
      m_ctl[0] = 32'h0;
      m_ctl[1] = 32'h0;
    end else if (op == 2'b10) begin
      m_off = 4;
      m_ctl[0] = 32'h9000_0000 | {26'h0, adr};
      m_ctl[1] = {8'hA0, dat[71:48]};
      m_ctl[2] = {8'hA0, dat[47:24]};
      m_ctl[3] = {8'hA0, dat[23:0]};
    end else begin
      m_ctl[0] = (op == 2'b01) ? (32'h8000_0000 | {26'h0, adr}) : (32'hF000_0000 | {24'h0, test});
      nxt = 0;
      acc = '0;
      for (int k = 1; k < TO && m_off == 0; k++) begin
        w = sched[k];
        if (op == 2'b01 && w[31:26] == 6'b110000) begin
          if (int'(w[25:24]) != nxt) begin
            m_err = 1'b1;
            m_off = k + 1;
          end else begin
            acc = acc | ({48'h0, w[23:0]} << (48 - 24 * nxt));
            nxt++;
            if (nxt == 3) m_off = k + 1;
          end
        end else if (op == 2'b11 && (w[31:24] == 8'hD0 || w[31:24] == 8'hD1) &&
                     w[23:8] == 16'h0 && w[7:0] == test) begin
          m_fail = w[24];
          m_off = k + 1;
        end
        if (m_off == 0 && k == TO - 1) begin
          m_err = 1'b1;
          m_off = TO;
        end
      end
      if (op == 2'b01) m_dat = acc;
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [5:0] adr, input logic [71:0] dat,
                         input logic [7:0] test, input int hold, output int off, output logic err,
                         output logic fail, output logic [71:0] rdat, output logic [31:0] ctl0);
    int n;
    model(op, adr, dat, test);
    off = -1;
    err = 1'b0;
    fail = 1'b0;
    rdat = '0;
    ctl0 = '0;
    n = 0;
    while (!bif.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready before request", {71'h0, bif.req_ready}, 72'h1);
    bif.req_valid = 1'b1;
    bif.req_op = op;
    bif.req_adr = adr;
    bif.req_dat = dat;
    bif.req_test = test;
    bif.status = $urandom;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_op = 2'($urandom);
    for (int k = 0; k < NS && off < 0; k++) begin
      chk($sformatf("ctl op%0d cyc%0d", op, k), {40'h0, bif.ctl}, {40'h0, m_ctl[k]});
      if (k == 0) ctl0 = bif.ctl;
      if (bif.rsp_valid) begin
        off = k;
      end else begin
        bif.status = sched[k];
        @(negedge clk);
      end
    end
    if (off < 0) begin
      chk("rsp_valid within cycle budget", 72'h0, 72'h1);
    end else begin
      err = bif.rsp_err;
      fail = bif.rsp_fail;
      rdat = bif.rsp_dat;
      for (int h = 0; h < hold; h++) begin
        bif.rsp_ready = 1'b0;
        bif.status = $urandom;
        @(negedge clk);
        chk("held rsp_valid", {71'h0, bif.rsp_valid}, 72'h1);
        chk("held rsp_dat", bif.rsp_dat, rdat);
        chk("held req_ready", {71'h0, bif.req_ready}, 72'h0);
        chk("held ctl", {40'h0, bif.ctl}, {40'h0, m_ctl[off]});
      end
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      chk("rsp_valid drop", {71'h0, bif.rsp_valid}, 72'h0);
      chk("rsp clear", {bif.rsp_err, bif.rsp_fail, bif.rsp_dat[69:0]}, 72'h0);
      chk("idle req_ready", {71'h0, bif.req_ready}, 72'h1);
      chk("idle ctl", {40'h0, bif.ctl}, {40'h0, m_ctl[off]});
    end
  endtask

  initial begin
    int          off;
    logic        err, fail;
    logic [71:0] rdat, dat;
    logic [31:0] c0;
    logic [1:0]  op, idx;
    logic [7:0]  test;
    int          t;

    bif.req_valid = 1'b0;
    bif.req_op = '0;
    bif.req_adr = '0;
    bif.req_dat = '0;
    bif.req_test = '0;
    bif.rsp_ready = 1'b0;
    bif.status = '0;
    reset = 1'b1;

    vecs[0] = '{2'b10, 6'h05, 72'h123456_789ABC_DEF012, 8'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0,
                0, 32'h9000_0005, 4, 1'b0, 1'b0, 72'h0};
    vecs[1] = '{2'b01, 6'h3F, 72'h0, 8'h00, 1, 4, 7, 32'hC0AA_AAAA, 32'hC1BB_BBBB, 32'hC2CC_CCCC,
                5, 32'h8000_003F, 8, 1'b0, 1'b0, 72'hAAAAAA_BBBBBB_CCCCCC};
    vecs[2] = '{2'b00, 6'h11, 72'h5, 8'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0,
                0, 32'h0000_0000, 1, 1'b0, 1'b0, 72'h0};
    vecs[3] = '{2'b11, 6'h00, 72'h0, 8'h07, 10, 0, 0, 32'hD000_0007, 32'h0, 32'h0,
                0, 32'hF000_0007, 11, 1'b0, 1'b0, 72'h0};
    vecs[4] = '{2'b11, 6'h00, 72'h0, 8'h07, 10, 0, 0, 32'hD100_0007, 32'h0, 32'h0,
                0, 32'hF000_0007, 11, 1'b0, 1'b1, 72'h0};
    vecs[5] = '{2'b11, 6'h00, 72'h0, 8'h07, 10, 0, 0, 32'hD000_0008, 32'h0, 32'h0,
                0, 32'hF000_0007, 16, 1'b1, 1'b0, 72'h0};
    vecs[6] = '{2'b01, 6'h2A, 72'h0, 8'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0,
                0, 32'h8000_002A, 16, 1'b1, 1'b0, 72'h0};
    vecs[7] = '{2'b01, 6'h01, 72'h0, 8'h00, 3, 0, 0, 32'hC2CC_CCCC, 32'h0, 32'h0,
                0, 32'h8000_0001, 4, 1'b1, 1'b0, 72'h0};
    vecs[8] = '{2'b01, 6'h02, 72'h0, 8'h00, 2, 5, 0, 32'hC011_1111, 32'hC122_2222, 32'h0,
                2, 32'h8000_0002, 16, 1'b1, 1'b0, 72'h111111_222222_000000};
    vecs[9] = '{2'b11, 6'h00, 72'h0, 8'h55, 2, 5, 15, 32'hC012_3456, 32'hD100_0009, 32'hD000_0055,
                0, 32'hF000_0055, 16, 1'b0, 1'b0, 72'h0};

    @(negedge clk);
    @(negedge clk);
    chk("reset ctl", {40'h0, bif.ctl}, 72'h0);
    chk("reset req_ready", {71'h0, bif.req_ready}, 72'h1);
    chk("reset rsp", {bif.rsp_valid, bif.rsp_err, bif.rsp_fail, bif.rsp_dat[68:0]}, 72'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NS; k++) sched[k] = 32'h0;
      sched[vecs[i].k0] = vecs[i].w0;
      sched[vecs[i].k1] = vecs[i].w1;
      sched[vecs[i].k2] = vecs[i].w2;
      run_txn(vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].test, vecs[i].hold, off, err, fail, rdat, c0);
      chk($sformatf("v%0d cmd word", i), {40'h0, c0}, {40'h0, vecs[i].e_ctl0});
      chk($sformatf("v%0d rsp latency", i), 72'(off), 72'(vecs[i].e_off));
      chk($sformatf("v%0d rsp_err", i), {71'h0, err}, {71'h0, vecs[i].e_err});
      chk($sformatf("v%0d rsp_fail", i), {71'h0, fail}, {71'h0, vecs[i].e_fail});
      chk($sformatf("v%0d rsp_dat", i), rdat, vecs[i].e_dat);
    end

    // Reset while the second write-data beat is on ctl.
    bif.req_valid = 1'b1;
    bif.req_op = 2'b10;
    bif.req_adr = 6'h09;
    bif.req_dat = 72'h111111_222222_333333;
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("wr cmd", {40'h0, bif.ctl}, {40'h0, 32'h9000_0009});
    @(negedge clk);
    chk("wr beat0", {40'h0, bif.ctl}, {40'h0, 32'hA011_1111});
    @(negedge clk);
    chk("wr beat1", {40'h0, bif.ctl}, {40'h0, 32'hA022_2222});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort ctl", {40'h0, bif.ctl}, 72'h0);
    chk("abort req_ready", {71'h0, bif.req_ready}, 72'h1);
    chk("abort rsp_valid", {71'h0, bif.rsp_valid}, 72'h0);
    @(negedge clk);
    chk("abort stays idle", {bif.rsp_valid, bif.ctl}, 33'h0);
    for (int k = 0; k < NS; k++) sched[k] = 32'h0;
    sched[2] = 32'hC0AB_CDEF;
    sched[3] = 32'hC101_2345;
    sched[4] = 32'hC267_89AB;
    run_txn(2'b01, 6'h10, 72'h0, 8'h00, 1, off, err, fail, rdat, c0);
    chk("post-reset read latency", 72'(off), 72'd5);
    chk("post-reset read err", {71'h0, err}, 72'h0);
    chk("post-reset read dat", rdat, 72'hABCDEF_012345_6789AB);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      dat = {8'($urandom), $urandom, $urandom};
      test = 8'($urandom);
      for (int k = 0; k < NS; k++) sched[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      if (op == 2'b01) begin
        t = $urandom_range(0, 4);
        for (int b = 0; b < 3; b++) begin
          idx = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(b);
          sched[t] = {6'b110000, idx, 24'($urandom)};
          t += $urandom_range(1, 6);
        end
      end else if (op == 2'b11) begin
        t = $urandom_range(0, 18);
        sched[t] = {($urandom_range(0, 1) == 1) ? 8'hD1 : 8'hD0, 16'h0,
                    ($urandom_range(0, 3) == 0) ? test + 8'd1 : test};
      end
      run_txn(op, 6'($urandom), dat, test, $urandom_range(0, 3), off, err, fail, rdat, c0);
      chk($sformatf("rnd%0d latency", i), 72'(off), 72'(m_off));
      chk($sformatf("rnd%0d rsp_err", i), {71'h0, err}, {71'h0, m_err});
      chk($sformatf("rnd%0d rsp_fail", i), {71'h0, fail}, {71'h0, m_fail});
      chk($sformatf("rnd%0d rsp_dat", i), rdat, m_dat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
